// File: rtl/ram_pkg.sv
// Shared definitions for the RAM burst reader.
// State encoding is kept here so the bench and other blocks agree on it.
package ram_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_READ  = 2'd1;
  localparam state_t S_DRAIN = 2'd2;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Command and output-stream handshake bundle for the burst reader.
// master drives commands and consumes words; slave is the reader.
interface ram_burst_reader_if #(
  parameter int width   = 8,
  parameter int widthad = 8
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [widthad-1:0] cmd_addr;
  logic [widthad:0]   cmd_len;
  logic               out_valid;
  logic               out_ready;
  logic [width-1:0]   out_data;
  logic               out_last;
  logic               done;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_data, out_last, done
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, out_ready,
    output cmd_ready, out_valid, out_data, out_last, done
  );

endinterface

// File: rtl/ram_rd_skid.sv
// Two-entry output buffer absorbing RAM read latency.
// Entry e0 is always the head presented downstream.
module ram_rd_skid #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic [1:0]       count
);

  logic [width-1:0] e0;
  logic [width-1:0] e1;

  assign dout = e0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0    <= '0;
      e1    <= '0;
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Streams a burst of consecutive RAM words out through a valid/ready port.
// Reads are throttled so buffered plus in-flight words never exceed two.
module ram_burst_reader
  import ram_pkg::*;
#(
  parameter int width   = 8,
  parameter int widthad = 8
) (
  input  logic                clk,
  input  logic                rst,
  ram_burst_reader_if.slave   bus,
  output logic [widthad-1:0]  rdaddress,
  input  logic [width-1:0]    q
);

  localparam logic [widthad:0]   LEN1 = (widthad+1)'(1);
  localparam logic [widthad-1:0] ADR1 = widthad'(1);

  state_t           state;
  logic [widthad:0] remaining;
  logic [widthad:0] left;
  logic             inflight;
  logic             done_q;
  logic [1:0]       count;
  logic [2:0]       occ;
  logic [width-1:0] dout;
  logic             valid;
  logic             last;
  logic             pop;
  logic             issue;
  logic             accept;

  assign valid  = (count != 2'd0);
  assign last   = valid && (left == LEN1);
  assign pop    = valid && bus.out_ready;
  assign accept = bus.cmd_valid && (state == S_IDLE);
  assign occ    = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue  = (state == S_READ) && (occ < 3'd2);

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.out_valid = valid;
  assign bus.out_data  = dout;
  assign bus.out_last  = last;
  assign bus.done      = done_q;

  ram_rd_skid #(
    .width(width)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .pop  (pop),
    .din  (q),
    .dout (dout),
    .count(count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rdaddress <= '0;
      remaining <= '0;
      left      <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      if (pop) left <= left - LEN1;
      unique case (1'b1)
        state == S_IDLE: begin
          if (accept) begin
            if (bus.cmd_len != '0) begin
              state     <= S_READ;
              rdaddress <= bus.cmd_addr;
              remaining <= bus.cmd_len;
              left      <= bus.cmd_len;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        state == S_READ: begin
          if (issue) begin
            remaining <= remaining - LEN1;
            // last issue keeps the final address on the bus
            if (remaining == LEN1) state <= S_DRAIN;
            else rdaddress <= rdaddress + ADR1;
          end
        end
        state == S_DRAIN: begin
          if (pop && last) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader with a registered RAM model.
// Expected streams come from mem[] indexed by (addr+i) mod 256.
module tb_ram_burst_reader;

  localparam int W = 8;
  localparam int A = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [A-1:0] rdaddress;
  logic [W-1:0] q;
  logic [W-1:0] mem [256];

  ram_burst_reader_if #(.width(W), .widthad(A)) bus ();

  ram_burst_reader #(.width(W), .widthad(A)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rdaddress(rdaddress),
    .q        (q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) q <= mem[rdaddress];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int acc_cyc;
  int rdy_mode = 0;
  int phase = 0;

  logic [W-1:0] got_d [$];
  bit           got_l [$];
  int           got_c [$];
  int           done_c [$];
  logic [A-1:0] ra_q [$];
  int           first_ov;
  int           stab_err;
  int           rdy_low;
  bit           prev_stall;
  logic [W-1:0] prev_d;
  logic         prev_l;
  logic [A-1:0] prev_ra;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_last);
        got_c.push_back(cyc);
      end
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (bus.done) done_c.push_back(cyc);
      if (!bus.cmd_ready) rdy_low++;
      if (prev_stall && (bus.out_data !== prev_d || bus.out_last !== prev_l))
        stab_err++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d = bus.out_data;
      prev_l = bus.out_last;
      if (rdaddress !== prev_ra) begin
        ra_q.push_back(rdaddress);
        prev_ra = rdaddress;
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      case (rdy_mode)
        1:       bus.out_ready = (phase % 4 == 0) || (phase % 4 == 3);
        2:       bus.out_ready = 1'($urandom % 2);
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_word(input int a, input int i);
    return mem[(a + i) % 256];
  endfunction

  task automatic clear_mon();
    got_d.delete();
    got_l.delete();
    got_c.delete();
    done_c.delete();
    ra_q.delete();
    first_ov   = -1;
    stab_err   = 0;
    rdy_low    = 0;
    prev_stall = 1'b0;
    prev_ra    = rdaddress;
  endtask

  task automatic send_cmd(input logic [A-1:0] a, input logic [A:0] l);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_c.size() == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.cmd_ready, bus.out_valid, bus.out_last, bus.done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 1000",
               {bus.cmd_ready, bus.out_valid, bus.out_last, bus.done});
    end
    n_chk++;
    if (rdaddress !== 8'h00 || bus.out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got ra=%h d=%h want 00/00", rdaddress, bus.out_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_mon();
    rdy_mode = 0;
    send_cmd(8'h10, 9'd4);
    wait_done(50);
    n_chk++;
    if (got_d.size() !== 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want 4", got_d.size());
    end
    for (int i = 0; i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== ref_word(8'h10, i) || got_l[i] !== (i == 3)
          || got_c[i] !== acc_cyc + 2 + i) begin
        n_fail++;
        $display("FAIL basic_word[%0d]: got %h/%b@%0d want %h/%b@%0d", i, got_d[i],
                 got_l[i], got_c[i], ref_word(8'h10, i), (i == 3), acc_cyc + 2 + i);
      end
    end
    n_chk++;
    if (first_ov !== acc_cyc + 2) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want %0d", first_ov, acc_cyc + 2);
    end
    n_chk++;
    if (done_c.size() !== 1 || done_c[0] !== acc_cyc + 6) begin
      n_fail++;
      $display("FAIL basic_done: got n=%0d want 1 at %0d", done_c.size(), acc_cyc + 6);
    end
  endtask

  task automatic test_len0();
    clear_mon();
    send_cmd(8'h33, 9'd0);
    wait_done(10);
    n_chk++;
    if (got_d.size() !== 0 || first_ov !== -1) begin
      n_fail++;
      $display("FAIL len0_out: got words=%0d ov=%0d want 0/-1", got_d.size(), first_ov);
    end
    n_chk++;
    if (done_c.size() !== 1 || done_c[0] !== acc_cyc) begin
      n_fail++;
      $display("FAIL len0_done: got n=%0d want 1 at %0d", done_c.size(), acc_cyc);
    end
    n_chk++;
    if (rdy_low !== 0) begin
      n_fail++;
      $display("FAIL len0_ready: got %0d low cycles want 0", rdy_low);
    end
  endtask

  task automatic test_wrap();
    logic [A-1:0] exp_ra [4];
    exp_ra = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    clear_mon();
    send_cmd(8'hFE, 9'd4);
    wait_done(50);
    n_chk++;
    if (ra_q.size() !== 4 || got_d.size() !== 4) begin
      n_fail++;
      $display("FAIL wrap_count: got ra=%0d words=%0d want 4/4", ra_q.size(), got_d.size());
    end
    for (int i = 0; i < ra_q.size() && i < 4; i++) begin
      n_chk++;
      if (ra_q[i] !== exp_ra[i]) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d]: got %h want %h", i, ra_q[i], exp_ra[i]);
      end
    end
    for (int i = 0; i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== ref_word(8'hFE, i) || got_l[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL wrap_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i],
                 ref_word(8'hFE, i), (i == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    clear_mon();
    rdy_mode = 1;
    phase = -1;
    send_cmd(8'h40, 9'd8);
    wait_done(100);
    rdy_mode = 0;
    n_chk++;
    if (got_d.size() !== 8) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want 8", got_d.size());
    end
    for (int i = 0; i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== ref_word(8'h40, i) || got_l[i] !== (i == 7)) begin
        n_fail++;
        $display("FAIL bp_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i],
                 ref_word(8'h40, i), (i == 7));
      end
    end
    n_chk++;
    if (stab_err !== 0 || done_c.size() !== 1) begin
      n_fail++;
      $display("FAIL bp_stable: got unstable=%0d done=%0d want 0/1", stab_err, done_c.size());
    end
  endtask

  task automatic test_full();
    int bad = 0;
    clear_mon();
    send_cmd(8'h80, 9'd256);
    wait_done(400);
    n_chk++;
    if (got_d.size() !== 256) begin
      n_fail++;
      $display("FAIL full_count: got %0d want 256", got_d.size());
    end
    for (int i = 0; i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== ref_word(8'h80, i) || got_l[i] !== (i == 255)) begin
        n_fail++;
        bad++;
        if (bad < 5)
          $display("FAIL full_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i],
                   ref_word(8'h80, i), (i == 255));
      end
    end
    n_chk++;
    if (got_c.size() !== 256 || got_c[255] - got_c[0] !== 255 || done_c.size() !== 1) begin
      n_fail++;
      $display("FAIL full_rate: got words=%0d done=%0d want 256 gapless, 1 done",
               got_c.size(), done_c.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_cmd(8'h20, 9'd16);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.cmd_ready, bus.out_valid, bus.out_last, bus.done} !== 4'b1000
        || rdaddress !== 8'h00 || bus.out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_async: got %b ra=%h d=%h want 1000/00/00",
               {bus.cmd_ready, bus.out_valid, bus.out_last, bus.done}, rdaddress, bus.out_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    n_chk++;
    if (done_c.size() !== 0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_done: got done=%0d ov=%b want 0/0", done_c.size(), bus.out_valid);
    end
    clear_mon();
    send_cmd(8'h00, 9'd2);
    wait_done(50);
    n_chk++;
    if (got_d.size() !== 2 || done_c.size() !== 1) begin
      n_fail++;
      $display("FAIL midrst_after: got words=%0d done=%0d want 2/1", got_d.size(), done_c.size());
    end
    for (int i = 0; i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== ref_word(0, i) || got_l[i] !== (i == 1)) begin
        n_fail++;
        $display("FAIL midrst_word[%0d]: got %h/%b want %h/%b", i, got_d[i], got_l[i],
                 ref_word(0, i), (i == 1));
      end
    end
  endtask

  task automatic test_random();
    int a;
    int l;
    for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
    rdy_mode = 2;
    for (int t = 0; t < 8; t++) begin
      a = int'($urandom % 256);
      l = int'($urandom_range(1, 24));
      clear_mon();
      send_cmd(A'(a), (A+1)'(l));
      wait_done(200);
      n_chk++;
      if (got_d.size() !== l || done_c.size() !== 1 || stab_err !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_count: got words=%0d done=%0d unstable=%0d want %0d/1/0",
                 t, got_d.size(), done_c.size(), stab_err, l);
      end
      for (int i = 0; i < got_d.size(); i++) begin
        n_chk++;
        if (got_d[i] !== ref_word(a, i) || got_l[i] !== (i == l - 1)) begin
          n_fail++;
          $display("FAIL rand%0d_word[%0d]: got %h/%b want %h/%b", t, i, got_d[i],
                   got_l[i], ref_word(a, i), (i == l - 1));
        end
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = W'(i);
    clear_mon();
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_backpressure();
    test_full();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 SHALL have parameter width, default 8, data word width in bits; equal to the attached RAM's width.
REQ-002 SHALL have parameter widthad, default 8, RAM address width; RAM depth is 2**widthad words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  burst request present.
REQ-006 SHALL have port cmd_ready  output  1  block idle, can accept a burst.
REQ-007 SHALL have port cmd_addr  input  widthad  start word address.
REQ-008 SHALL have port cmd_len  input  widthad+1  burst length in words, 0..2**widthad.
REQ-009 SHALL have port rdaddress  output  widthad  read address to the RAM read port.
REQ-010 SHALL have port q  input  width  registered RAM read data, valid one cycle after rdaddress.
REQ-011 SHALL have port out_valid  output  1  out_data holds a word.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-013 SHALL have port out_data  output  width  read word.
REQ-014 SHALL have port out_last  output  1  qualifies the final word of a burst.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 SHALL have states IDLE, READ and DRAIN; cmd_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: a command handshake (cmd_valid&cmd_ready) with cmd_len>0 SHALL latch the address and length and go to READ; with cmd_len=0 it SHALL stay in IDLE and pulse done in the next cycle, producing no output word.
REQ-018 READ: the block SHALL issue one read per cycle while (buffered words + in-flight reads - words popped this cycle) < 2, driving rdaddress and incrementing the address by 1 per issue.
REQ-019 The address SHALL wrap modulo 2**widthad; for example, start 0xFE with length 4 reads 0xFE, 0xFF, 0x00, 0x01.
REQ-020 q SHALL be captured into the 2-entry output buffer exactly one cycle after each issued read; q SHALL be ignored in all other cycles.
REQ-021 After all reads are issued the block SHALL move to DRAIN; it SHALL return to IDLE on the out handshake of the word carrying out_last, and done SHALL pulse in the following cycle.
REQ-022 Latency: for a command accepted at edge E0, rdaddress SHALL present the first address after E0, and out_valid SHALL rise after E2.
REQ-023 Throughput: with out_ready held at 1, one word per cycle SHALL be output with no bubbles.
REQ-024 Backpressure: while out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable; no word SHALL be lost or duplicated.
REQ-025 Words SHALL be output in address order; out_last SHALL be 1 only on word number cmd_len.
REQ-026 rdaddress SHALL hold its last value when no read is issued.
REQ-027 A write to the same address in the same cycle as the read SHALL return the old data (RAM read-before-write); the block SHALL not compensate for it.

Reset
REQ-028 On rst: state=IDLE, cmd_ready=1, out_valid=0, out_last=0, done=0, rdaddress=0, out_data=0, buffer and in-flight counters cleared.
REQ-029 Reset during READ or DRAIN SHALL abort the burst; buffered words SHALL be discarded and done SHALL not pulse.

Structure
REQ-030 The state encoding (IDLE/READ/DRAIN) SHALL be defined in the shared package ram_pkg; width and widthad SHALL stay module parameters.
REQ-031 The 2-entry output buffer SHALL be a sub-module ram_rd_skid (width parameter, push/pop, count output); the RAM itself SHALL be external to the block.

Verification
REQ-032 RAM preloaded mem[i]=i, width=8: cmd addr 0x10, len 4, out_ready=1 -> out_data 0x10, 0x11, 0x12, 0x13 on consecutive cycles, out_valid rises 2 cycles after acceptance, out_last on 0x13, done one cycle later.
REQ-033 Wrap: cmd addr 0xFE, len 4 -> rdaddress 0xFE, 0xFF, 0x00, 0x01; out_data matches.
REQ-034 Backpressure: len 8, out_ready toggling 1,0,0,1 repeating -> all 8 words in order, stable while stalled, at most 2 reads outstanding plus buffered.
REQ-035 cmd_len=0 -> no out_valid, done pulses one cycle after acceptance, cmd_ready stays 1.
REQ-036 Full burst: len 256 (widthad=8), addr 0x80 -> 256 words, last word mem[0x7F].
REQ-037 rst asserted mid-READ of a len 16 burst -> outputs reach reset values immediately (asynchronously), no done pulse; a new burst with addr 0x00, len 2 then returns 0x00, 0x01.
